i2c_req_arbiter: RTL and testbench
==================================

// Module: i2c_req_arbiter
// PURPOSE
//  Shares one i2c master FSM between N_REQ independent requesters (sensor poller, config loader, host bridge,...).
//  Round-robin arbitration; latches the winner's address/rw/data and pulses the master trigger.
//  Waits for completion or a watchdog timeout, then returns read data and status to the winner.
//  Enforces a bus-free gap between transactions. Sits between client logic and the i2c master.
// PARAMETERS
//  N_REQ       4      number of requesters (2..8)
//  IDX_W       2      index width, $clog2(N_REQ)
//  GAP_CYCLES  250    idle clk cycles enforced after each transaction (bus free time)
//  TIMEOUT     65535  max clk cycles from trigger to m_done before abort
//  TO_W        16     width of timeout/gap counter (must hold TIMEOUT and GAP_CYCLES)
// PORTS
//  clk          in   1          system clock (100 MHz)
//  rst_n        in   1          asynchronous active-low reset
//  req          in   N_REQ      request level per client; held with fields stable until its rsp_valid
//  req_addr     in   7*N_REQ    7-bit slave address per client, client i at [7*i+:7]
//  req_rw       in   N_REQ      0 = write, 1 = read
//  req_wdata    in   8*N_REQ    write byte per client, client i at [8*i+:8]
//  grant        out  N_REQ      one-hot, high while client's transaction is in flight
//  rsp_valid    out  N_REQ      one-hot 1-cycle completion pulse
//  rsp_rdata    out  8          read byte, valid with rsp_valid (0 for writes/errors)
//  rsp_nack     out  1          slave NACKed, valid with rsp_valid
//  rsp_timeout  out  1          watchdog expired, valid with rsp_valid
//  m_trigger    out  1          1-cycle start pulse to master
//  m_address    out  7          latched address to master, stable from LAUNCH to RESP
//  m_rw         out  1          latched rw to master
//  m_din        out  8          latched write byte to master
//  m_done       in   1          master 1-cycle completion pulse
//  m_nack       in   1          master NACK status, sampled with m_done
//  m_dout       in   8          master read byte, sampled with m_done
//  busy         out  1          high in any state other than IDLE
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, rr_ptr=0, all outputs 0, counters 0; aborts any transaction, no rsp pulse.
//  FSM: IDLE -> LAUNCH -> WAIT_DONE -> RESP -> GAP -> IDLE.
//  IDLE: if |req, winner = first asserted req scanning rr_ptr, rr_ptr+1,... mod N_REQ.
//   Same edge: latch winner idx, addr, rw, wdata into m_*; set grant[idx]; go LAUNCH.
//  LAUNCH: m_trigger=1 for exactly this cycle; clear counter; go WAIT_DONE.
//  WAIT_DONE: counter++ each cycle.
//   m_done=1: capture m_dout (forced 0 if rw=0 or m_nack), m_nack; go RESP.
//   counter==TIMEOUT-1 with no m_done: set timeout flag; go RESP.
//   m_done and timeout on the same cycle: m_done wins, rsp_timeout=0.
//  RESP: rsp_valid[idx]=1, rsp_rdata/rsp_nack/rsp_timeout driven for this cycle only;
//   grant cleared; rr_ptr <= idx+1 mod N_REQ; counter cleared; go GAP.
//  GAP: counter++; at counter==GAP_CYCLES-1 go IDLE. Requests are not sampled in GAP.
//   Total gap = GAP_CYCLES cycles; GAP_CYCLES=0 treated as 1.
//  Latency: req rise in IDLE -> grant next edge; m_trigger one cycle after grant;
//   rsp_valid one cycle after m_done.
//  rsp_* fields hold their last value between pulses. Consumers qualify with rsp_valid only.
//  Client dropping req mid-transaction: ignored; transaction completes, rsp_valid still pulses.
//   Re-arbitrated only if req is high again in IDLE.
//  m_done outside WAIT_DONE (late done after timeout, spurious): ignored.
//  Requests whose index is >= N_REQ do not exist; req bits never X-propagate into grant
//   (winner logic fully defined).
//  No starvation: each asserted client is served within N_REQ transactions.
// TESTING
//  T1 single write: req[1]=1, addr=0x50, rw=0, wdata=0xA5; m_done after 40 cycles, m_nack=0
//   -> one m_trigger, m_address=0x50, m_din=0xA5; rsp_valid=4'b0010; rsp_rdata=0, nack=0.
//  T2 read: req[2], rw=1, addr=0x68; m_done with m_dout=0x3C
//   -> rsp_valid[2] one cycle after m_done, rsp_rdata=0x3C.
//  T3 fairness: req=4'b1111 held continuously
//   -> grants in order 0,1,2,3,0; each grant exactly GAP_CYCLES+ cycles after previous rsp_valid.
//  T4 NACK and timeout: m_nack=1 with m_done -> rsp_nack=1, rdata=0.
//   Never assert m_done -> rsp_timeout=1 exactly TIMEOUT cycles after m_trigger; later m_done ignored.
//  T5 reset mid-WAIT_DONE: rst_n=0 async
//   -> grant, busy, m_trigger=0 immediately; no rsp_valid; after release, req[3] wins (rr_ptr=0 scan).
//  T6 drop req: req[0] falls one cycle after grant
//   -> transaction still completes, rsp_valid[0] pulses, no second trigger.

Source files
------------

// File: rtl/i2c_req_arbiter.sv
// Round-robin arbiter that shares one i2c master between N_REQ clients, with a
// completion watchdog and an enforced bus-free gap after every transaction.
module i2c_req_arbiter #(
    parameter int N_REQ      = 4,
    parameter int IDX_W      = 2,
    parameter int GAP_CYCLES = 250,
    parameter int TIMEOUT    = 65535,
    parameter int TO_W       = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req,
    input  logic [7*N_REQ-1:0]   req_addr,
    input  logic [N_REQ-1:0]     req_rw,
    input  logic [8*N_REQ-1:0]   req_wdata,
    output logic [N_REQ-1:0]     grant,
    output logic [N_REQ-1:0]     rsp_valid,
    output logic [7:0]           rsp_rdata,
    output logic                 rsp_nack,
    output logic                 rsp_timeout,
    output logic                 m_trigger,
    output logic [6:0]           m_address,
    output logic                 m_rw,
    output logic [7:0]           m_din,
    input  logic                 m_done,
    input  logic                 m_nack,
    input  logic [7:0]           m_dout,
    output logic                 busy
);

    localparam int GAP_EFF = (GAP_CYCLES < 1) ? 1 : GAP_CYCLES;
    localparam int TO_EFF  = (TIMEOUT < 1) ? 1 : TIMEOUT;
    localparam logic [TO_W-1:0]  GAP_LAST = TO_W'(GAP_EFF - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TO_EFF - 1);
    localparam logic [IDX_W-1:0] IDX_MAX  = IDX_W'(N_REQ - 1);
    localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LAUNCH = 3'd1,
        ST_WAIT   = 3'd2,
        ST_RESP   = 3'd3,
        ST_GAP    = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [IDX_W-1:0]   r_rr_ptr;
    logic [IDX_W-1:0]   r_idx;
    logic [TO_W-1:0]    r_cnt;
    logic [N_REQ-1:0]   r_grant;
    logic [N_REQ-1:0]   r_rsp_valid;
    logic [7:0]         r_rsp_rdata;
    logic               r_rsp_nack;
    logic               r_rsp_timeout;
    logic               r_m_trigger;
    logic [6:0]         r_m_address;
    logic               r_m_rw;
    logic [7:0]         r_m_din;
    logic               r_busy;
    logic [IDX_W-1:0]   w_win_idx;
    logic               w_win_found;
    logic               w_done_ok;
    logic               w_time_out;

    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        s = (s >= N_REQ) ? (s - N_REQ) : s;
        return IDX_W'(s);
    endfunction

    // Round-robin winner: scanned from the far end so the client nearest the pointer wins.
    always_comb begin
        w_win_idx   = '0;
        w_win_found = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            w_win_idx   = req[wrap_add(r_rr_ptr, k)] ? wrap_add(r_rr_ptr, k) : w_win_idx;
            w_win_found = w_win_found | req[wrap_add(r_rr_ptr, k)];
        end
    end

    // Next-state logic; m_done takes priority over the watchdog on the same cycle.
    always_comb begin
        w_next_state = r_state;
        w_done_ok    = 1'b0;
        w_time_out   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_win_found) begin
                    w_next_state = ST_LAUNCH;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_LAUNCH: w_next_state = ST_WAIT;
            ST_WAIT: begin
                if (m_done) begin
                    w_done_ok    = 1'b1;
                    w_next_state = ST_RESP;
                end else if (r_cnt == TO_LAST) begin
                    w_time_out   = 1'b1;
                    w_next_state = ST_RESP;
                end else begin
                    w_next_state = ST_WAIT;
                end
            end
            ST_RESP: w_next_state = ST_GAP;
            ST_GAP: begin
                if (r_cnt == GAP_LAST) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_GAP;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Datapath: latched transaction fields, counters, round-robin pointer and response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr      <= '0;
            r_idx         <= '0;
            r_cnt         <= '0;
            r_grant       <= '0;
            r_rsp_valid   <= '0;
            r_rsp_rdata   <= 8'h00;
            r_rsp_nack    <= 1'b0;
            r_rsp_timeout <= 1'b0;
            r_m_trigger   <= 1'b0;
            r_m_address   <= 7'h00;
            r_m_rw        <= 1'b0;
            r_m_din       <= 8'h00;
            r_busy        <= 1'b0;
        end else begin
            // Trigger follows LAUNCH by one edge so it lands one cycle after grant.
            r_m_trigger <= (r_state == ST_LAUNCH);
            r_rsp_valid <= '0;
            r_busy      <= (w_next_state != ST_IDLE);
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
                    if (w_win_found) begin
                        r_idx       <= w_win_idx;
                        r_grant     <= ONE_HOT0 << w_win_idx;
                        r_m_address <= req_addr[7*w_win_idx +: 7];
                        r_m_rw      <= req_rw[w_win_idx];
                        r_m_din     <= req_wdata[8*w_win_idx +: 8];
                    end else begin
                        r_grant     <= '0;
                    end
                end
                ST_LAUNCH: r_cnt <= '0;
                ST_WAIT: begin
                    r_cnt <= r_cnt + TO_W'(1);
                    if (w_done_ok || w_time_out) begin
                        r_rsp_valid   <= ONE_HOT0 << r_idx;
                        r_rsp_nack    <= w_done_ok & m_nack;
                        r_rsp_timeout <= w_time_out;
                        r_rsp_rdata   <= (w_done_ok && r_m_rw && !m_nack) ? m_dout : 8'h00;
                    end else begin
                        r_rsp_valid   <= '0;
                    end
                end
                ST_RESP: begin
                    r_grant  <= '0;
                    r_cnt    <= '0;
                    r_rr_ptr <= (r_idx == IDX_MAX) ? '0 : (r_idx + IDX_W'(1));
                end
                ST_GAP:  r_cnt <= r_cnt + TO_W'(1);
                default: r_cnt <= '0;
            endcase
        end
    end

    assign grant       = r_grant;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_nack    = r_rsp_nack;
    assign rsp_timeout = r_rsp_timeout;
    assign m_trigger   = r_m_trigger;
    assign m_address   = r_m_address;
    assign m_rw        = r_m_rw;
    assign m_din       = r_m_din;
    assign busy        = r_busy;

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Self-checking bench for i2c_req_arbiter: directed table, hand-written corner
// sequences and random transactions checked against a round-robin reference model.
module tb_i2c_req_arbiter;

    localparam int N   = 4;
    localparam int GAP = 6;
    localparam int TMO = 100;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req = '0;
    logic [7*N-1:0] req_addr = '0;
    logic [N-1:0]   req_rw = '0;
    logic [8*N-1:0] req_wdata = '0;
    logic [N-1:0]   grant;
    logic [N-1:0]   rsp_valid;
    logic [7:0]     rsp_rdata;
    logic           rsp_nack;
    logic           rsp_timeout;
    logic           m_trigger;
    logic [6:0]     m_address;
    logic           m_rw;
    logic [7:0]     m_din;
    logic           m_done = 1'b0;
    logic           m_nack = 1'b0;
    logic [7:0]     m_dout = 8'h00;
    logic           busy;

    i2c_req_arbiter #(
        .N_REQ(N), .IDX_W(2), .GAP_CYCLES(GAP), .TIMEOUT(TMO), .TO_W(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_addr(req_addr), .req_rw(req_rw),
        .req_wdata(req_wdata), .grant(grant), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_nack(rsp_nack), .rsp_timeout(rsp_timeout), .m_trigger(m_trigger),
        .m_address(m_address), .m_rw(m_rw), .m_din(m_din), .m_done(m_done),
        .m_nack(m_nack), .m_dout(m_dout), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic [3:0] rw;
        logic [6:0] addr;
        logic [7:0] wdata;
        int         delay;
        logic       nack;
        logic [7:0] dout;
        logic       drop;
        int         exp_idx;
        logic [7:0] exp_rdata;
        logic       exp_nack;
        logic       exp_to;
    } vec_t;

    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;
    int   mptr;
    vec_t tbl [9];

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [3:0] oh(input int idx);
        logic [3:0] one;
        one = 4'b0001;
        return one << idx;
    endfunction

    function automatic vec_t mkv(input logic [3:0] rq, input logic [3:0] rw, input logic [6:0] a,
                                 input logic [7:0] wd, input int d, input logic nk, input logic [7:0] dout,
                                 input logic drop, input int ei, input logic [7:0] er, input logic en,
                                 input logic et);
        vec_t v;
        v.req = rq; v.rw = rw; v.addr = a; v.wdata = wd; v.delay = d; v.nack = nk;
        v.dout = dout; v.drop = drop; v.exp_idx = ei; v.exp_rdata = er; v.exp_nack = en;
        v.exp_to = et;
        return v;
    endfunction

    // Reference model: pick the first requester at or after ptr, then apply the response rules.
    function automatic vec_t model(input vec_t v, input int ptr);
        vec_t r;
        bit   found;
        bit   to;
        r = v;
        found = 1'b0;
        r.exp_idx = 0;
        for (int k = 0; k < N; k++) begin
            if (!found && v.req[(ptr + k) % N]) begin
                found = 1'b1;
                r.exp_idx = (ptr + k) % N;
            end
        end
        to = (v.delay < 0) || (v.delay >= TMO);
        r.exp_to    = to;
        r.exp_nack  = !to && v.nack;
        r.exp_rdata = (!to && !v.nack && v.rw[r.exp_idx]) ? v.dout : 8'h00;
        return r;
    endfunction

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 400) begin
            tick();
            n++;
        end
        chk("idle_wait", busy, 0);
    endtask

    task automatic run_txn(input vec_t v);
        int         k;
        int         extra;
        int         exp_lat;
        bit         got;
        logic [6:0] ea;
        logic [7:0] ed;
        wait_idle();
        for (int i = 0; i < N; i++) begin
            req_addr[7*i +: 7]  = v.addr + 7'(i);
            req_wdata[8*i +: 8] = v.wdata ^ 8'(i);
        end
        req_rw = v.rw;
        req    = v.req;
        ea = v.addr + 7'(v.exp_idx);
        ed = v.wdata ^ 8'(v.exp_idx);
        tick();
        chk("grant", grant, oh(v.exp_idx));
        chk("busy", busy, 1);
        chk("trigger_early", m_trigger, 0);
        if (v.drop) req = '0;
        tick();
        chk("trigger", m_trigger, 1);
        chk("m_address", m_address, ea);
        chk("m_rw", m_rw, v.rw[v.exp_idx]);
        chk("m_din", m_din, ed);
        k = 0; extra = 0; got = 1'b0;
        while (!got && k <= TMO + 4) begin
            if (k == v.delay) begin
                m_done = 1'b1; m_nack = v.nack; m_dout = v.dout;
            end
            tick();
            m_done = 1'b0;
            k++;
            if (m_trigger) extra++;
            if (rsp_valid != '0) got = 1'b1;
        end
        exp_lat = v.exp_to ? TMO : v.delay + 1;
        chk("rsp_seen", got, 1);
        chk("rsp_valid", rsp_valid, oh(v.exp_idx));
        chk("rsp_rdata", rsp_rdata, v.exp_rdata);
        chk("rsp_nack", rsp_nack, v.exp_nack);
        chk("rsp_timeout", rsp_timeout, v.exp_to);
        chk("rsp_latency", k, exp_lat);
        chk("trigger_once", extra, 0);
        req = '0;
        if (v.exp_to) m_done = 1'b1;
        tick();
        m_done = 1'b0;
        chk("rsp_pulse", rsp_valid, 0);
        chk("grant_clear", grant, 0);
        if (v.exp_to) begin
            tick();
            chk("late_done", rsp_valid, 0);
        end
    endtask

    initial begin
        vec_t v;
        int   prev;
        int   expi;
        int   t_rsp;
        int   n;
        int   r;

        tbl[0] = mkv(4'b0010, 4'b0000, 7'h4F, 8'hA4, 40, 1'b0, 8'h77, 1'b0, 1, 8'h00, 1'b0, 1'b0);
        tbl[1] = mkv(4'b0100, 4'b0100, 7'h66, 8'h00,  5, 1'b0, 8'h3C, 1'b0, 2, 8'h3C, 1'b0, 1'b0);
        tbl[2] = mkv(4'b0011, 4'b0001, 7'h10, 8'h00,  7, 1'b1, 8'h99, 1'b0, 0, 8'h00, 1'b1, 1'b0);
        tbl[3] = mkv(4'b1001, 4'b1000, 7'h20, 8'h30,  1, 1'b0, 8'h5A, 1'b0, 3, 8'h5A, 1'b0, 1'b0);
        tbl[4] = mkv(4'b0100, 4'b0100, 7'h01, 8'hF0, -1, 1'b0, 8'h11, 1'b0, 2, 8'h00, 1'b0, 1'b1);
        tbl[5] = mkv(4'b1111, 4'b0000, 7'h40, 8'h0F,  0, 1'b0, 8'hEE, 1'b0, 3, 8'h00, 1'b0, 1'b0);
        tbl[6] = mkv(4'b0101, 4'b1111, 7'h7C, 8'h55,  3, 1'b1, 8'h12, 1'b0, 0, 8'h00, 1'b1, 1'b0);
        tbl[7] = mkv(4'b0101, 4'b1111, 7'h7C, 8'h55, TMO - 1, 1'b0, 8'hC3, 1'b0, 2, 8'hC3, 1'b0, 1'b0);
        tbl[8] = mkv(4'b0001, 4'b0000, 7'h30, 8'h81, 10, 1'b0, 8'h44, 1'b1, 0, 8'h00, 1'b0, 1'b0);

        tick(); tick();
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);
        chk("rst_trigger", m_trigger, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_m_address", m_address, 0);
        #2 rst_n = 1'b1;
        tick();
        chk("idle_busy", busy, 0);

        for (int i = 0; i < 9; i++) run_txn(tbl[i]);

        wait_idle();
        m_done = 1'b1;
        tick();
        m_done = 1'b0;
        tick(); tick();
        chk("idle_no_regrant", grant, 0);
        chk("idle_spurious_done", rsp_valid, 0);
        chk("idle_stay", busy, 0);

        req = 4'b0010;
        tick();
        chk("pre_reset_grant", grant, 4'b0010);
        tick(); tick(); tick();
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_grant", grant, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_trigger", m_trigger, 0);
        chk("async_rst_rsp", rsp_valid, 0);
        req = '0;
        tick(); tick();
        #2 rst_n = 1'b1;
        tick();
        chk("post_rst_rsp", rsp_valid, 0);
        run_txn(mkv(4'b1000, 4'b0000, 7'h22, 8'h6B, 4, 1'b0, 8'h00, 1'b0, 3, 8'h00, 1'b0, 1'b0));

        req_rw = '0;
        req = 4'b1111;
        prev = N - 1;
        t_rsp = 0;
        for (int i = 0; i < 5; i++) begin
            expi = (prev + 1) % N;
            n = 0;
            while (grant == '0 && n < 60) begin
                tick();
                n++;
            end
            chk("rr_order", grant, oh(expi));
            if (i > 0) chk("gap_spacing", cyc - t_rsp, GAP + 2);
            tick();
            tick();
            m_done = 1'b1; m_nack = 1'b0;
            tick();
            m_done = 1'b0;
            chk("rr_rsp", rsp_valid, oh(expi));
            t_rsp = cyc;
            prev = expi;
            tick();
        end
        req = '0;
        mptr = (prev + 1) % N;

        for (int i = 0; i < 30; i++) begin
            v.req   = 4'($urandom_range(1, 15));
            v.rw    = 4'($urandom);
            v.addr  = 7'($urandom);
            v.wdata = 8'($urandom);
            v.nack  = ($urandom_range(0, 3) == 0);
            v.dout  = 8'($urandom);
            v.drop  = ($urandom_range(0, 4) == 0);
            r = $urandom_range(0, 19);
            v.delay = (r == 0) ? -1 : (r == 1) ? TMO - 1 : $urandom_range(0, 15);
            v = model(v, mptr);
            run_txn(v);
            mptr = (v.exp_idx + 1) % N;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
